// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code parser with make/break/E0 decode, a programmable code remap table
// and a show-ahead event FIFO popped via a valid/ready handshake.
module ps2_key_event_queue #(
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned NUM_REMAP    = 4,
   parameter bit          DROP_RELEASE = 1'b0,
   localparam int unsigned IDX_W = (NUM_REMAP > 1) ? $clog2(NUM_REMAP) : 1,
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             i_inclock,
   input  logic             i_reset,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_valid,
   input  logic             i_remap_we,
   input  logic [IDX_W-1:0] i_remap_idx,
   input  logic [7:0]       i_remap_from,
   input  logic [7:0]       i_remap_to,
   input  logic             i_remap_valid,
   output logic [7:0]       o_evt_code,
   output logic             o_evt_release,
   output logic             o_evt_extended,
   output logic             o_evt_valid,
   input  logic             i_evt_ready,
   output logic [CNT_W-1:0] o_fifo_count,
   output logic             o_overflow,
   input  logic             i_overflow_clr,
   output logic [7:0]       o_last_code
);

   localparam logic [7:0] BYTE_EXT = 8'hE0;
   localparam logic [7:0] BYTE_BRK = 8'hF0;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   typedef struct packed {
      logic       ext;
      logic       rel;
      logic [7:0] code;
   } evt_t;

   state_t           r_state;
   evt_t             r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;
   logic [7:0]       r_last_code;
   logic [7:0]       r_remap_from  [NUM_REMAP];
   logic [7:0]       r_remap_to    [NUM_REMAP];
   logic             r_remap_valid [NUM_REMAP];

   logic       w_ctrl;
   logic       w_emit;
   logic       w_ext;
   logic       w_rel;
   logic [7:0] w_remap_code;
   logic [7:0] w_code;
   logic       w_full;
   logic       w_pop;
   logic       w_push_req;
   logic       w_push;
   logic       w_drop;

   // Link-level control bytes abort any partial prefix sequence.
   always_comb begin
      w_ctrl = 1'b0;
      case (i_rx_data)
         8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: w_ctrl = 1'b1;
         default:                                                 w_ctrl = 1'b0;
      endcase
   end

   // Parser state: prefixes accumulate, any data or control byte returns to idle.
   always_ff @(posedge i_inclock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else if (i_rx_valid) begin
         if (i_rx_data == BYTE_EXT) begin
            r_state <= (r_state == S_BRK || r_state == S_EXT_BRK) ? S_EXT_BRK : S_EXT;
         end else if (i_rx_data == BYTE_BRK) begin
            r_state <= (r_state == S_EXT || r_state == S_EXT_BRK) ? S_EXT_BRK : S_BRK;
         end else begin
            r_state <= S_IDLE;
         end
      end
   end

   always_comb begin
      w_emit = 1'b0;
      w_ext  = 1'b0;
      w_rel  = 1'b0;
      if (i_rx_valid && !w_ctrl && i_rx_data != BYTE_EXT && i_rx_data != BYTE_BRK) begin
         w_emit = 1'b1;
         w_ext  = (r_state == S_EXT) || (r_state == S_EXT_BRK);
         w_rel  = (r_state == S_BRK) || (r_state == S_EXT_BRK);
      end
   end

   // Scan from the top so the lowest matching valid entry is the one that sticks.
   always_comb begin
      w_remap_code = i_rx_data;
      for (int i = int'(NUM_REMAP) - 1; i >= 0; i--) begin
         if (r_remap_valid[i] && r_remap_from[i] == i_rx_data) begin
            w_remap_code = r_remap_to[i];
         end
      end
      w_code = w_ext ? i_rx_data : w_remap_code;
   end

   always_ff @(posedge i_inclock or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < int'(NUM_REMAP); i++) begin
            r_remap_from[i]  <= 8'h00;
            r_remap_to[i]    <= 8'h00;
            r_remap_valid[i] <= 1'b0;
         end
      end else if (i_remap_we) begin
         for (int i = 0; i < int'(NUM_REMAP); i++) begin
            if (i_remap_idx == IDX_W'(i)) begin
               r_remap_from[i]  <= i_remap_from;
               r_remap_to[i]    <= i_remap_to;
               r_remap_valid[i] <= i_remap_valid;
            end
         end
      end
   end

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   always_comb begin
      w_full     = (r_count == CNT_W'(FIFO_DEPTH));
      w_pop      = (r_count != '0) && i_evt_ready;
      w_push_req = w_emit && !(DROP_RELEASE && w_rel);
      w_push     = w_push_req && (!w_full || w_pop);
      w_drop     = w_push_req && w_full && !w_pop;
   end

   always_ff @(posedge i_inclock or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= '{ext: w_ext, rel: w_rel, code: w_code};
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky overflow: a fresh drop beats a simultaneous clear.
   always_ff @(posedge i_inclock or posedge i_reset) begin
      if (i_reset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (i_overflow_clr) begin
         r_overflow <= 1'b0;
      end
   end

   always_ff @(posedge i_inclock or posedge i_reset) begin
      if (i_reset) begin
         r_last_code <= 8'h00;
      end else if (w_emit && !w_rel) begin
         r_last_code <= w_code;
      end
   end

   assign o_evt_code     = r_mem[r_rd_ptr].code;
   assign o_evt_release  = r_mem[r_rd_ptr].rel;
   assign o_evt_extended = r_mem[r_rd_ptr].ext;
   assign o_evt_valid    = (r_count != '0);
   assign o_fifo_count   = r_count;
   assign o_overflow     = r_overflow;
   assign o_last_code    = r_last_code;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench for ps2_key_event_queue: decode, remap, overflow, control bytes and reset.
module tb_ps2_key_event_queue;

   logic       clk;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       remap_we;
   logic [1:0] remap_idx;
   logic [7:0] remap_from;
   logic [7:0] remap_to;
   logic       remap_valid;
   logic       evt_ready;
   logic       overflow_clr;

   logic [7:0] evt_code,  evt_code_d;
   logic       evt_rel,   evt_rel_d;
   logic       evt_ext,   evt_ext_d;
   logic       evt_valid, evt_valid_d;
   logic [3:0] count,     count_d;
   logic       ovf,       ovf_d;
   logic [7:0] last_code, last_code_d;

   int n_tests = 0;
   int n_fail  = 0;

   ps2_key_event_queue #(.FIFO_DEPTH(8), .NUM_REMAP(4), .DROP_RELEASE(1'b0)) dut (
      .i_inclock(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .i_remap_we(remap_we), .i_remap_idx(remap_idx), .i_remap_from(remap_from),
      .i_remap_to(remap_to), .i_remap_valid(remap_valid),
      .o_evt_code(evt_code), .o_evt_release(evt_rel), .o_evt_extended(evt_ext),
      .o_evt_valid(evt_valid), .i_evt_ready(evt_ready), .o_fifo_count(count),
      .o_overflow(ovf), .i_overflow_clr(overflow_clr), .o_last_code(last_code)
   );

   ps2_key_event_queue #(.FIFO_DEPTH(8), .NUM_REMAP(4), .DROP_RELEASE(1'b1)) dut_drop (
      .i_inclock(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .i_remap_we(remap_we), .i_remap_idx(remap_idx), .i_remap_from(remap_from),
      .i_remap_to(remap_to), .i_remap_valid(remap_valid),
      .o_evt_code(evt_code_d), .o_evt_release(evt_rel_d), .o_evt_extended(evt_ext_d),
      .o_evt_valid(evt_valid_d), .i_evt_ready(evt_ready), .o_fifo_count(count_d),
      .o_overflow(ovf_d), .i_overflow_clr(overflow_clr), .o_last_code(last_code_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One active cycle of stimulus, then inputs return to idle.
   task automatic step(input logic [7:0] d, input logic v, input logic rdy, input logic clr);
      @(negedge clk);
      rx_data = d; rx_valid = v; evt_ready = rdy; overflow_clr = clr;
      @(negedge clk);
      rx_valid = 1'b0; evt_ready = 1'b0; overflow_clr = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      step(d, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic pop();
      step(8'h00, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic remap_wr(input logic [1:0] idx, input logic [7:0] f, input logic [7:0] t,
                           input logic vb, input logic rxv, input logic [7:0] d);
      @(negedge clk);
      remap_we = 1'b1; remap_idx = idx; remap_from = f; remap_to = t; remap_valid = vb;
      rx_data = d; rx_valid = rxv;
      @(negedge clk);
      remap_we = 1'b0; rx_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] drain_exp [8];
      drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
      reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; remap_we = 1'b0; remap_idx = 2'd0;
      remap_from = 8'h00; remap_to = 8'h00; remap_valid = 1'b0; evt_ready = 1'b0;
      overflow_clr = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(evt_valid), 32'd0);
      chk("rst_code", 32'(evt_code), 32'h00);
      chk("rst_flags", {30'd0, evt_rel, evt_ext}, 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_last", 32'(last_code), 32'h00);

      send(8'h1C);
      chk("press_valid", 32'(evt_valid), 32'd1);
      chk("press_code", 32'(evt_code), 32'h1C);
      chk("press_flags", {30'd0, evt_rel, evt_ext}, 32'd0);
      chk("press_count", 32'(count), 32'd1);
      chk("press_last", 32'(last_code), 32'h1C);
      pop();
      chk("pop_valid", 32'(evt_valid), 32'd0);
      chk("pop_count", 32'(count), 32'd0);

      send(8'hF0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h75);
      chk("rel_count", 32'(count), 32'd2);
      chk("rel1_code", 32'(evt_code), 32'h1C);
      chk("rel1_flags", {30'd0, evt_rel, evt_ext}, 32'b10);
      chk("rel_last", 32'(last_code), 32'h1C);
      chk("droprel_count", 32'(count_d), 32'd0);
      pop();
      chk("rel2_code", 32'(evt_code), 32'h75);
      chk("rel2_flags", {30'd0, evt_rel, evt_ext}, 32'b11);
      pop();
      chk("rel_drained", 32'(count), 32'd0);

      remap_wr(2'd0, 8'h31, 8'h6E, 1'b1, 1'b0, 8'h00);
      send(8'h31);
      chk("remap_code", 32'(evt_code), 32'h6E);
      chk("remap_last", 32'(last_code), 32'h6E);
      pop();
      send(8'hE0); send(8'h31);
      chk("remap_ext_code", 32'(evt_code), 32'h31);
      chk("remap_ext_flags", {30'd0, evt_rel, evt_ext}, 32'b01);
      pop();
      remap_wr(2'd0, 8'h16, 8'h22, 1'b1, 1'b0, 8'h00);
      remap_wr(2'd1, 8'h16, 8'h33, 1'b1, 1'b0, 8'h00);
      send(8'h16);
      chk("remap_prio", 32'(evt_code), 32'h22);
      pop();
      remap_wr(2'd2, 8'h4D, 8'h55, 1'b1, 1'b1, 8'h4D);
      chk("remap_same_cycle", 32'(evt_code), 32'h4D);
      pop();
      send(8'h4D);
      chk("remap_after_wr", 32'(evt_code), 32'h55);
      pop();
      chk("remap_drained", 32'(count), 32'd0);

      for (int i = 1; i <= 9; i++) send(8'(i));
      chk("full_count", 32'(count), 32'd8);
      chk("full_ovf", 32'(ovf), 32'd1);
      chk("full_head", 32'(evt_code), 32'h01);
      chk("full_last", 32'(last_code), 32'h09);
      step(8'h00, 1'b0, 1'b0, 1'b1);
      chk("ovf_clr", 32'(ovf), 32'd0);
      step(8'h0B, 1'b1, 1'b0, 1'b1);
      chk("ovf_set_wins", 32'(ovf), 32'd1);
      chk("ovf_set_count", 32'(count), 32'd8);
      step(8'h00, 1'b0, 1'b0, 1'b1);
      chk("ovf_clr2", 32'(ovf), 32'd0);
      step(8'h0A, 1'b1, 1'b1, 1'b0);
      chk("pushpop_count", 32'(count), 32'd8);
      chk("pushpop_ovf", 32'(ovf), 32'd0);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("drain%0d", k), 32'(evt_code), 32'(drain_exp[k]));
         pop();
      end
      chk("drain_count", 32'(count), 32'd0);

      send(8'hE0); send(8'hAA); send(8'h1C);
      chk("ctrl_count", 32'(count), 32'd1);
      chk("ctrl_code", 32'(evt_code), 32'h1C);
      chk("ctrl_flags", {30'd0, evt_rel, evt_ext}, 32'b00);
      pop();
      send(8'hF0); send(8'hFA); send(8'h1C);
      chk("ctrl_brk_flags", {30'd0, evt_rel, evt_ext}, 32'b00);
      pop();

      send(8'hF0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      send(8'h1C);
      chk("midrst_count", 32'(count), 32'd1);
      chk("midrst_code", 32'(evt_code), 32'h1C);
      chk("midrst_flags", {30'd0, evt_rel, evt_ext}, 32'b00);
      chk("midrst_ovf", 32'(ovf), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
